vblank_scheduler: RTL and testbench

Sequences the game-logic update clients (player move, bullet move, collision, score, and so on) once per frame, inside the vertical blanking interval reported by the VGA sync generator. It detects the end of the visible frame from `disp_en` and `row`, then grants each enabled client in turn with a req/done handshake. It enforces a per-client timeout and flags an overrun if active display resumes before all clients finish. It sits between the sync generator and the game-state modules, so state never changes while pixels are being drawn.

---
 rtl/vblank_scheduler_if.sv | 22 ++
 rtl/vblank_scheduler.sv | 95 +++++++++
 tb/tb_vblank_scheduler.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vblank_scheduler_if.sv
// vblank_scheduler_if: sync-generator inputs, client handshake and status bundle for the vblank scheduler
interface vblank_scheduler_if #(parameter int NCLIENT = 4);
  logic               disp_en;
  logic [31:0]        row;
  logic [NCLIENT-1:0] client_en;
  logic [NCLIENT-1:0] done;
  logic [NCLIENT-1:0] req;
  logic               busy;
  logic [2:0]         active_client;
  logic               frame_done;
  logic               overrun;
  logic [NCLIENT-1:0] timeout_err;
  logic [15:0]        frame_cnt;
  modport master (
    input  disp_en, row, client_en, done,
    output req, busy, active_client, frame_done, overrun, timeout_err, frame_cnt
  );
  modport slave (
    output disp_en, row, client_en, done,
    input  req, busy, active_client, frame_done, overrun, timeout_err, frame_cnt
  );
endinterface

// File: rtl/vblank_scheduler.sv
// vblank_scheduler: grants each enabled game-logic client in turn during vertical blanking
module vblank_scheduler #(
  parameter int NCLIENT = 4,
  parameter int TIMEOUT = 4096,
  parameter int V_DISP  = 480
) (
  input logic               vga_clk,
  input logic               reset,
  vblank_scheduler_if.master bus
);
  localparam int CW = $clog2(TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, GRANT, WAIT, FIN} state_t;
  state_t             state, state_nxt;
  logic               disp_en_q;
  logic [NCLIENT-1:0] en_l, sel;
  logic [2:0]         idx, first_idx, next_idx;
  logic               has_next;
  logic [CW-1:0]      cnt;
  logic               vblank_start, vis_start, abort, tmo, done_cur, hit;
  // a falling display-enable only counts as vblank on the last visible line
  assign vblank_start = disp_en_q && !bus.disp_en && bus.row == 32'(V_DISP - 1);
  assign vis_start    = !disp_en_q && bus.disp_en;
  assign abort        = vis_start && bus.busy;
  assign sel          = NCLIENT'(1) << idx;
  assign done_cur     = |(bus.done & sel);
  assign tmo          = cnt == CW'(TIMEOUT - 1);
  assign hit          = done_cur || tmo;
  // lowest enabled client at vblank start, and next latched client above the current one
  always_comb begin
    first_idx = '0;
    next_idx  = '0;
    has_next  = 1'b0;
    for (int i = NCLIENT - 1; i >= 0; i--) begin
      if (bus.client_en[i]) first_idx = 3'(i);
      if (en_l[i] && 3'(i) > idx) begin
        next_idx = 3'(i);
        has_next = 1'b1;
      end
    end
  end
  // state register
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end
  // next-state: overrun abort takes priority over done or timeout
  always_comb begin
    state_nxt = state == IDLE  ? (vblank_start ? (|bus.client_en ? GRANT : FIN) : IDLE)
              : state == GRANT ? (abort ? IDLE : WAIT)
              : state == WAIT  ? (abort ? IDLE : !hit ? WAIT : has_next ? GRANT : FIN)
              : IDLE;
  end
  // grant is a level tied to WAIT so an asynchronous reset drops it at once
  always_comb begin
    bus.req = state == WAIT ? sel : '0;
  end
  // per-frame bookkeeping, timeout counter and registered status pulses
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      disp_en_q         <= 1'b0;
      en_l              <= '0;
      idx               <= '0;
      cnt               <= '0;
      bus.busy          <= 1'b0;
      bus.active_client <= '0;
      bus.frame_done    <= 1'b0;
      bus.overrun       <= 1'b0;
      bus.timeout_err   <= '0;
      bus.frame_cnt     <= '0;
    end else begin
      disp_en_q      <= bus.disp_en;
      bus.frame_done <= state == FIN && !abort;
      bus.overrun    <= abort;
      if (abort || state == FIN) bus.busy <= 1'b0;
      else if (state == GRANT) bus.busy <= 1'b1;
      if (state == IDLE && vblank_start) begin
        en_l            <= bus.client_en;
        idx             <= first_idx;
        bus.timeout_err <= '0;
        bus.frame_cnt   <= bus.frame_cnt + 16'd1;
      end
      if (state == GRANT && !abort) begin
        bus.active_client <= idx;
        cnt               <= '0;
      end
      if (state == WAIT && !abort) begin
        cnt <= cnt + CW'(1);
        if (hit) begin
          if (!done_cur) bus.timeout_err <= bus.timeout_err | sel;
          idx <= next_idx;
        end
      end
    end
  end
endmodule

// File: tb/tb_vblank_scheduler.sv
// tb_vblank_scheduler: scoreboard bench for grant order, timing, timeout, overrun and reset behaviour
module tb_vblank_scheduler;
  logic vga_clk = 1'b0;
  logic reset;
  always #5 vga_clk = ~vga_clk;
  vblank_scheduler_if #(.NCLIENT(4)) bus ();
  vblank_scheduler #(.NCLIENT(4), .TIMEOUT(16), .V_DISP(480)) dut (
    .vga_clk(vga_clk),
    .reset(reset),
    .bus(bus.master)
  );
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  int          dly[4];
  int          age[4];
  logic        auto_resp;
  logic [3:0]  spur;
  logic [3:0]  prev_req;
  int          len, gap, exp_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ev_grant(input int g, input int ac, input logic [3:0] r);
    return {4'h1, 8'(g), 4'(ac), 4'h0, r, 8'h0};
  endfunction
  function automatic logic [31:0] ev_fall(input int l, input int ac, input logic [3:0] r);
    return {4'h4, 8'(l), 4'(ac), 4'h0, r, 8'h0};
  endfunction
  function automatic logic [31:0] ev_fd(input logic [3:0] te);
    return {4'h2, 4'h0, te, 20'h0};
  endfunction
  function automatic logic [31:0] ev_ov(input logic [3:0] r, input logic b);
    return {4'h3, 4'h0, r, 3'h0, b, 16'h0};
  endfunction

  task automatic observe(input logic [31:0] ev);
    if (exp_q.size() == 0) chk("extra_event", ev, 32'h0);
    else chk("event", ev, exp_q.pop_front());
  endtask

  task automatic monitor();
    if (reset) begin
      prev_req = '0;
      len = 0;
      gap = 0;
      return;
    end
    if (prev_req != 0 && bus.req != prev_req) observe(ev_fall(len, int'(bus.active_client), prev_req));
    if (bus.req != 0 && prev_req == 0) begin
      observe(ev_grant(gap, int'(bus.active_client), bus.req));
      len = 0;
    end
    if (bus.req != 0) len++;
    if (bus.frame_done) observe(ev_fd(bus.timeout_err));
    if (bus.overrun) observe(ev_ov(bus.req, bus.busy));
    if (!bus.busy || bus.req != 0) gap = 0;
    else gap++;
    prev_req = bus.req;
  endtask

  task automatic tick();
    logic [3:0] d;
    @(posedge vga_clk);
    #1;
    d = spur;
    for (int i = 0; i < 4; i++) begin
      age[i] = bus.req[i] ? age[i] + 1 : 0;
      if (bus.req[i] && dly[i] >= 0 && age[i] == dly[i]) d[i] = 1'b1;
    end
    if (auto_resp) bus.done = d;
    @(negedge vga_clk);
    monitor();
  endtask

  task automatic vblank();
    bus.row = 32'd479;
    bus.disp_en = 1'b1;
    tick();
    bus.disp_en = 1'b0;
    tick();
    exp_cnt = (exp_cnt + 1) & 32'hFFFF;
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
    chk("drain", 32'(exp_q.size()), 32'h0);
    repeat (4) tick();
  endtask

  task automatic push_client(input int g, input int ac, input int l);
    exp_q.push_back(ev_grant(g, ac, 4'(1 << ac)));
    exp_q.push_back(ev_fall(l, ac, 4'(1 << ac)));
  endtask

  task automatic push_full(input logic [3:0] te);
    for (int i = 0; i < 4; i++) push_client(i == 0 ? 0 : 1, i, 3);
    exp_q.push_back(ev_fd(te));
  endtask

  initial begin
    reset = 1'b1;
    bus.disp_en = 1'b0;
    bus.row = '0;
    bus.client_en = '0;
    bus.done = '0;
    auto_resp = 1'b1;
    spur = '0;
    dly = '{3, 3, 3, 3};
    age = '{0, 0, 0, 0};
    prev_req = '0;
    len = 0;
    gap = 0;
    exp_cnt = 0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    chk("rst_req", 32'(bus.req), 32'h0);
    chk("rst_busy", 32'(bus.busy), 32'h0);
    chk("rst_ac", 32'(bus.active_client), 32'h0);
    chk("rst_fd", 32'(bus.frame_done), 32'h0);
    chk("rst_ov", 32'(bus.overrun), 32'h0);
    chk("rst_terr", 32'(bus.timeout_err), 32'h0);
    chk("rst_cnt", 32'(bus.frame_cnt), 32'h0);

    bus.client_en = 4'b1111;
    push_full(4'h0);
    vblank();
    drain(100);
    chk("nom_cnt", 32'(bus.frame_cnt), 32'(exp_cnt));
    chk("nom_terr", 32'(bus.timeout_err), 32'h0);
    chk("nom_busy", 32'(bus.busy), 32'h0);

    bus.client_en = 4'b1010;
    spur = 4'b0101;
    push_client(0, 1, 3);
    push_client(1, 3, 3);
    exp_q.push_back(ev_fd(4'h0));
    vblank();
    repeat (3) tick();
    bus.client_en = 4'b0101;
    drain(100);
    spur = '0;
    chk("sparse_cnt", 32'(bus.frame_cnt), 32'(exp_cnt));

    bus.client_en = 4'b1111;
    dly[2] = -1;
    push_client(0, 0, 3);
    push_client(1, 1, 3);
    push_client(1, 2, 16);
    push_client(1, 3, 3);
    exp_q.push_back(ev_fd(4'b0100));
    vblank();
    drain(200);
    chk("tmo_terr", 32'(bus.timeout_err), 32'h4);
    dly[2] = 3;
    push_full(4'h0);
    vblank();
    chk("tmo_clear", 32'(bus.timeout_err), 32'h0);
    drain(100);

    auto_resp = 1'b0;
    bus.done = '0;
    bus.client_en = 4'b0001;
    exp_q.push_back(ev_grant(0, 0, 4'b0001));
    vblank();
    repeat (3) tick();
    exp_q.push_back(ev_fall(3, 0, 4'b0001));
    exp_q.push_back(ev_ov(4'h0, 1'b0));
    bus.disp_en = 1'b1;
    tick();
    chk("ov_req", 32'(bus.req), 32'h0);
    chk("ov_busy", 32'(bus.busy), 32'h0);
    drain(10);

    exp_q.push_back(ev_grant(0, 0, 4'b0001));
    vblank();
    repeat (3) tick();
    exp_q.push_back(ev_fall(3, 0, 4'b0001));
    exp_q.push_back(ev_ov(4'h0, 1'b0));
    bus.disp_en = 1'b1;
    bus.done = 4'b0001;
    tick();
    repeat (3) tick();
    bus.done = '0;
    drain(10);
    chk("ov_cnt", 32'(bus.frame_cnt), 32'(exp_cnt));
    auto_resp = 1'b1;

    bus.client_en = 4'b1111;
    for (int r = 0; r < 479; r++) begin
      bus.row = 32'(r);
      bus.disp_en = 1'b1;
      tick();
      bus.disp_en = 1'b0;
      tick();
    end
    repeat (4) tick();
    chk("filter_cnt", 32'(bus.frame_cnt), 32'(exp_cnt));
    chk("filter_busy", 32'(bus.busy), 32'h0);

    bus.client_en = 4'b0000;
    exp_q.push_back(ev_fd(4'h0));
    vblank();
    drain(20);
    chk("empty_cnt", 32'(bus.frame_cnt), 32'(exp_cnt));

    bus.client_en = 4'b1111;
    dly[0] = 10;
    exp_q.push_back(ev_grant(0, 0, 4'b0001));
    vblank();
    repeat (4) tick();
    reset = 1'b1;
    #1;
    chk("rst_mid_req", 32'(bus.req), 32'h0);
    tick();
    chk("rst_mid_busy", 32'(bus.busy), 32'h0);
    chk("rst_mid_ac", 32'(bus.active_client), 32'h0);
    chk("rst_mid_cnt", 32'(bus.frame_cnt), 32'h0);
    chk("rst_mid_terr", 32'(bus.timeout_err), 32'h0);
    chk("rst_mid_fd", 32'(bus.frame_done), 32'h0);
    chk("rst_mid_ov", 32'(bus.overrun), 32'h0);
    exp_cnt = 0;
    reset = 1'b0;
    dly[0] = 3;
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("rst_no_req", 32'(bus.req), 32'h0);
    end
    push_full(4'h0);
    vblank();
    drain(100);
    chk("rst_after_cnt", 32'(bus.frame_cnt), 32'(exp_cnt));

    bus.client_en = 4'b0000;
    for (int f = 0; f < 2000; f++) begin
      exp_q.push_back(ev_fd(4'h0));
      vblank();
    end
    drain(20);
    chk("many_cnt", 32'(bus.frame_cnt), 32'(exp_cnt));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
